// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the one-tact MIPS core. It holds the program
// counter, presents it combinationally to a word-addressed instruction memory,
// and captures the returned word into the IF/ID slot for the decoder.
// Redirects issued by decode for the instruction in the slot load a new PC and
// squash the single wrong-path word being fetched that same cycle.
//
// Parameters:
//   RESET_PC      word address loaded into the PC on reset
//   PC_STEP       sequential PC increment (1: memory is word-addressed)
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   stall         hold PC, IF/ID slot and counter this cycle
//   branch_taken  decode: slot instruction is a taken branch
//   branch_offset signed 16-bit word offset for the branch
//   jump          decode: slot instruction is J
//   jump_target   26-bit J-format target field
//   jr            decode: slot instruction is JR
//   jr_addr       register value used as the JR target
//   imem_addr     address to instruction memory (always equal to the PC)
//   imem_data     instruction word returned combinationally by memory
//   instr         IF/ID instruction word
//   instr_pc      address the IF/ID instruction was fetched from
//   instr_valid   IF/ID slot holds a real instruction
//   fetch_count   number of valid instructions loaded into IF/ID
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] PC_STEP  = 32'h00000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [31:0] fetch_count
);

  // FILL: slot empty since reset, nothing fetched yet. RUN: streaming.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] slot_next_pc;
  logic [31:0] branch_off_ext;
  logic [31:0] redirect_target;
  logic        redirect;

  // Redirect targets are relative to the instruction in the slot, not to the
  // PC currently being fetched (which is already one word ahead of it).
  assign slot_next_pc   = instr_pc_q + PC_STEP;
  assign branch_off_ext = {{16{branch_offset[15]}}, branch_offset};

  // Decode's control signals are meaningless for an empty slot (bubble or
  // FILL), so they are masked with the slot's valid bit.
  assign redirect = instr_valid_q & (jr | jump | branch_taken);

  // Target selection with jr > jump > branch priority. Branch arithmetic is
  // plain 32-bit addition so it wraps modulo 2^32.
  always_comb begin
    redirect_target = slot_next_pc + branch_off_ext;
    if (jr) begin
      redirect_target = jr_addr;
    end else if (jump) begin
      redirect_target = {slot_next_pc[31:26], jump_target};
    end
  end

  // Next-state logic. Redirect beats stall: the slot instruction has already
  // resolved its control flow, so the wrong-path word at imem_data is dropped
  // and the PC moves to the target even while the pipeline is otherwise held.
  // The slot word and its address are left as they were on a redirect since
  // the cleared valid bit already marks them as dead.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      pc_d          = redirect_target;
      instr_valid_d = 1'b0;
    end else if (!stall) begin
      instr_d       = imem_data;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + PC_STEP;
      fetch_count_d = fetch_count_q + 32'd1;
    end

    // The first non-stalled cycle after reset performs the first fetch, after
    // which the unit never returns to FILL short of another reset.
    if (state_q == FILL && !stall) begin
      state_d = RUN;
    end
  end

  // Single state register for the FSM and every datapath flop; reset wins
  // over any simultaneous stall or redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h00000000;
      instr_pc_q    <= 32'h00000000;
      instr_valid_q <= 1'b0;
      fetch_count_q <= 32'h00000000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // The memory address is the PC itself with no extra register, so the word
  // for pc_q is available in the same cycle.
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. Two instances share all inputs: one with
// the default reset PC and one with RESET_PC = 32'hFFFFFFFF for the wrap
// scenario. Each instruction memory returns addr + 32'h100. A reference model
// tracks the default instance; every predicted fetch is pushed onto a
// scoreboard queue and popped when the DUT loads its slot.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;

  logic [31:0] imem_addr, imem_data, instr, instr_pc, fetch_count;
  logic        instr_valid;

  logic [31:0] w_imem_addr, w_imem_data, w_instr, w_instr_pc, w_fetch_count;
  logic        w_instr_valid;

  int pass_cnt;
  int total_cnt;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } fetch_t;

  fetch_t sb[$];

  // Reference model state for the default-reset instance.
  logic [31:0] m_pc, m_instr, m_instr_pc, m_count;
  logic        m_valid;
  logic        fetched;

  assign imem_data   = imem_addr + 32'h100;
  assign w_imem_data = w_imem_addr + 32'h100;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFFF)) dut_w (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
    .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid),
    .fetch_count(w_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the reference model by one cycle using the currently driven
  // inputs, queue any predicted fetch, then move past the next rising edge.
  task automatic tick();
    logic [31:0] p1;
    logic [31:0] tgt;
    fetch_t      e;
    fetched = 1'b0;
    p1 = m_instr_pc + 32'd1;
    if (jr) tgt = jr_addr;
    else if (jump) tgt = {p1[31:26], jump_target};
    else tgt = p1 + {{16{branch_offset[15]}}, branch_offset};
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_instr_pc = 32'h0; m_valid = 1'b0; m_count = 32'h0;
      sb.delete();
    end else if (m_valid && (jr || jump || branch_taken)) begin
      m_pc = tgt;
      m_valid = 1'b0;
    end else if (!stall) begin
      e.word = m_pc + 32'h100;
      e.addr = m_pc;
      sb.push_back(e);
      m_instr = e.word; m_instr_pc = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 32'd1; m_count = m_count + 32'd1;
      fetched = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
    jump = 1'b0; jump_target = 26'h0; jr = 1'b0; jr_addr = 32'h0;
  endtask

  task automatic test_reset();
    clear_ctrl();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (imem_addr !== 32'h0) $display("[TB] FAIL reset_imem_addr: got %h expected %h", imem_addr, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (instr !== 32'h0) $display("[TB] FAIL reset_instr: got %h expected %h", instr, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (instr_pc !== 32'h0) $display("[TB] FAIL reset_instr_pc: got %h expected %h", instr_pc, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected %b", instr_valid, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (fetch_count !== 32'h0) $display("[TB] FAIL reset_count: got %0d expected %0d", fetch_count, 0);
    else pass_cnt++;
    total_cnt++;
    if (w_imem_addr !== 32'hFFFFFFFF) $display("[TB] FAIL reset_w_imem_addr: got %h expected %h", w_imem_addr, 32'hFFFFFFFF);
    else pass_cnt++;
  endtask

  task automatic test_sequential();
    fetch_t e;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (!fetched || sb.size() == 0) begin
        $display("[TB] FAIL seq_scoreboard_%0d: got empty queue expected one entry", i);
      end else begin
        e = sb.pop_front();
        if (instr !== e.word || instr_pc !== e.addr || instr_valid !== 1'b1)
          $display("[TB] FAIL seq_slot_%0d: got %h@%h v=%b expected %h@%h v=1", i, instr, instr_pc, instr_valid, e.word, e.addr);
        else pass_cnt++;
      end
      total_cnt++;
      if (instr !== 32'h100 + i || instr_pc !== i)
        $display("[TB] FAIL seq_const_%0d: got %h@%h expected %h@%h", i, instr, instr_pc, 32'h100 + i, i);
      else pass_cnt++;
    end
    total_cnt++;
    if (fetch_count !== 32'd4) $display("[TB] FAIL seq_count: got %0d expected %0d", fetch_count, 4);
    else pass_cnt++;
    total_cnt++;
    if (imem_addr !== 32'd4) $display("[TB] FAIL seq_imem_addr: got %h expected %h", imem_addr, 32'd4);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    fetch_t e;
    branch_taken = 1'b1;
    branch_offset = 16'hFFFE;
    tick();
    total_cnt++;
    if (imem_addr !== 32'd2 || instr_valid !== 1'b0 || fetch_count !== 32'd4)
      $display("[TB] FAIL branch_redirect: got pc=%h v=%b cnt=%0d expected pc=2 v=0 cnt=4", imem_addr, instr_valid, fetch_count);
    else pass_cnt++;
    clear_ctrl();
    tick();
    total_cnt++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL branch_scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (instr !== e.word || instr_pc !== e.addr || instr_pc !== 32'd2 || instr_valid !== 1'b1)
        $display("[TB] FAIL branch_target_slot: got %h@%h v=%b expected %h@%h v=1", instr, instr_pc, instr_valid, e.word, 32'd2);
      else pass_cnt++;
    end
    total_cnt++;
    if (fetch_count !== 32'd5) $display("[TB] FAIL branch_count: got %0d expected %0d", fetch_count, 5);
    else pass_cnt++;
  endtask

  task automatic test_jump();
    fetch_t e;
    jr = 1'b1;
    jr_addr = 32'h0C000005;
    tick();
    clear_ctrl();
    tick();
    void'(sb.pop_front());
    total_cnt++;
    if (instr_pc !== 32'h0C000005 || instr_valid !== 1'b1)
      $display("[TB] FAIL jr_slot: got %h v=%b expected %h v=1", instr_pc, instr_valid, 32'h0C000005);
    else pass_cnt++;
    jump = 1'b1;
    jump_target = 26'h0000010;
    tick();
    total_cnt++;
    if (imem_addr !== 32'h0C000010 || instr_valid !== 1'b0)
      $display("[TB] FAIL jump_target: got pc=%h v=%b expected pc=%h v=0", imem_addr, instr_valid, 32'h0C000010);
    else pass_cnt++;
    clear_ctrl();
    tick();
    total_cnt++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL jump_scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (instr !== e.word || instr_pc !== 32'h0C000010)
        $display("[TB] FAIL jump_slot: got %h@%h expected %h@%h", instr, instr_pc, e.word, 32'h0C000010);
      else pass_cnt++;
    end
    jr = 1'b1; jr_addr = 32'h40;
    jump = 1'b1; jump_target = 26'h3;
    branch_taken = 1'b1; branch_offset = 16'h7;
    tick();
    total_cnt++;
    if (imem_addr !== 32'h40 || instr_valid !== 1'b0)
      $display("[TB] FAIL jr_priority: got pc=%h v=%b expected pc=%h v=0", imem_addr, instr_valid, 32'h40);
    else pass_cnt++;
    clear_ctrl();
    tick();
    total_cnt++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL jr_prio_scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (instr !== e.word || instr_pc !== 32'h40)
        $display("[TB] FAIL jr_prio_slot: got %h@%h expected %h@%h", instr, instr_pc, e.word, 32'h40);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    fetch_t e;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (imem_addr !== m_pc || instr !== m_instr || instr_pc !== 32'h40 ||
          instr_valid !== 1'b1 || fetch_count !== m_count || imem_addr !== 32'h41)
        $display("[TB] FAIL stall_hold_%0d: got pc=%h %h@%h v=%b cnt=%0d expected pc=%h %h@%h v=1 cnt=%0d",
                 i, imem_addr, instr, instr_pc, instr_valid, fetch_count, m_pc, m_instr, 32'h40, m_count);
      else pass_cnt++;
    end
    stall = 1'b0;
    tick();
    total_cnt++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL stall_scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (instr !== e.word || instr_pc !== 32'h41 || fetch_count !== m_count)
        $display("[TB] FAIL stall_resume: got %h@%h cnt=%0d expected %h@%h cnt=%0d", instr, instr_pc, fetch_count, e.word, 32'h41, m_count);
      else pass_cnt++;
    end
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_offset = 16'h0003;
    tick();
    total_cnt++;
    if (imem_addr !== 32'h45 || instr_valid !== 1'b0)
      $display("[TB] FAIL stall_branch: got pc=%h v=%b expected pc=%h v=0", imem_addr, instr_valid, 32'h45);
    else pass_cnt++;
    clear_ctrl();
    tick();
    total_cnt++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL stall_branch_scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (instr !== e.word || instr_pc !== 32'h45)
        $display("[TB] FAIL stall_branch_slot: got %h@%h expected %h@%h", instr, instr_pc, e.word, 32'h45);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (w_instr_pc !== 32'hFFFFFFFF || w_instr !== 32'h000000FF || w_instr_valid !== 1'b1)
      $display("[TB] FAIL wrap_first: got %h@%h v=%b expected %h@%h v=1", w_instr, w_instr_pc, w_instr_valid, 32'h000000FF, 32'hFFFFFFFF);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (w_instr_pc !== 32'h0 || w_instr !== 32'h100 || w_fetch_count !== 32'd2)
      $display("[TB] FAIL wrap_second: got %h@%h cnt=%0d expected %h@%h cnt=2", w_instr, w_instr_pc, w_fetch_count, 32'h100, 32'h0);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    branch_taken = 1'b1;
    branch_offset = 16'h0001;
    tick();
    total_cnt++;
    if (w_imem_addr !== 32'h1 || w_instr_valid !== 1'b0)
      $display("[TB] FAIL wrap_branch: got pc=%h v=%b expected pc=%h v=0", w_imem_addr, w_instr_valid, 32'h1);
    else pass_cnt++;
    clear_ctrl();
    sb.delete();
  endtask

  task automatic test_reset_redirect();
    fetch_t e;
    tick();
    sb.delete();
    rst = 1'b1;
    branch_taken = 1'b1;
    branch_offset = 16'h0010;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (imem_addr !== 32'h0 || instr_valid !== 1'b0 || fetch_count !== 32'h0)
      $display("[TB] FAIL rst_over_redirect: got pc=%h v=%b cnt=%0d expected pc=0 v=0 cnt=0", imem_addr, instr_valid, fetch_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL ignored_branch_scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (instr !== e.word || instr_pc !== 32'h0 || instr_valid !== 1'b1 || imem_addr !== 32'h1)
        $display("[TB] FAIL ignored_branch: got %h@%h v=%b pc=%h expected %h@%h v=1 pc=%h", instr, instr_pc, instr_valid, imem_addr, e.word, 32'h0, 32'h1);
      else pass_cnt++;
    end
    clear_ctrl();
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    m_pc = 32'h0; m_instr = 32'h0; m_instr_pc = 32'h0; m_valid = 1'b0; m_count = 32'h0;
    fetched = 1'b0;
    rst = 1'b1;
    clear_ctrl();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_reset_redirect();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the one-tact MIPS core: holds the program counter, drives the word address into the combinational instruction memory, and registers the returned word into an IF/ID slot for the decoder. It applies redirects (branch, jump, jump-register) issued by decode for the instruction currently in the slot, squashing the one wrong-path fetch. It supports a pipeline stall and keeps a fetched-instruction counter.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset (word address)
- PC_STEP, 1, sequential increment; instruction memory is word-addressed

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID slot this cycle
- branch_taken  in  1  decode: slot instruction is a taken branch
- branch_offset  in  16  signed word offset for branch
- jump  in  1  decode: slot instruction is J
- jump_target  in  26  J-format target field
- jr  in  1  decode: slot instruction is JR
- jr_addr  in  32  register value for JR
- imem_addr  out  32  address to instruction memory (= pc, combinational)
- imem_data  in  32  instruction word returned combinationally
- instr  out  32  IF/ID instruction word
- instr_pc  out  32  address of instr
- instr_valid  out  1  IF/ID slot holds a real instruction
- fetch_count  out  32  number of valid instructions loaded into IF/ID

## Operation
- State: pc (32), IF/ID slot {instr, instr_pc, instr_valid}, fetch_count (32).
- Two-state FSM: FILL (after reset, slot empty) and RUN. FILL -> RUN on first non-stalled cycle; RUN has no exit except rst.
- redirect = instr_valid & (jr | jump | branch_taken). Redirect inputs ignored when instr_valid=0.
- Target priority when several asserted: jr > jump > branch.
  - jr: target = jr_addr.
  - jump: target = {p1[31:26], jump_target}, p1 = instr_pc + PC_STEP.
  - branch: target = p1 + sign_extend(branch_offset), 32-bit, wraps mod 2^32.
- Per-cycle update priority: rst > redirect > stall > sequential.
  - rst: pc <= RESET_PC; instr <= 0; instr_pc <= 0; instr_valid <= 0; fetch_count <= 0; FSM <= FILL.
  - redirect: pc <= target; instr_valid <= 0 (wrong-path word at imem_data discarded); instr/instr_pc may hold; fetch_count unchanged. Redirect overrides a simultaneous stall.
  - stall (no redirect): pc, slot, fetch_count hold.
  - sequential: instr <= imem_data; instr_pc <= pc; instr_valid <= 1; pc <= pc + PC_STEP (wraps 32'hFFFFFFFF -> 0); fetch_count <= fetch_count + 1 (wraps).
- imem_addr always equals pc; no registered address.

## Timing
- Reset values: imem_addr = RESET_PC, instr = 0, instr_pc = 0, instr_valid = 0, fetch_count = 0.
- First instruction (address RESET_PC) valid in slot one edge after rst deasserts (if no stall).
- Sequential throughput: one instruction per cycle.
- Redirect penalty: one bubble. Edge N: redirect seen, slot goes invalid, pc = target. Edge N+1: slot holds instruction at target.
- Stall asserted in cycle k: all outputs identical in cycle k+1 to cycle k.
- rst asserted mid-operation: takes effect on that edge regardless of stall/redirect.
- Redirect asserted with instr_valid=0 (bubble or FILL): no effect; sequential/stall rules apply.

## Test plan
- Reset then run 4 cycles, imem returns addr+32'h100 -> slot shows (0x100,0),(0x101,1),(0x102,2),(0x103,3); fetch_count=4; valid low only before first edge.
- Slot instr_pc=3, branch_taken=1, offset=16'hFFFE -> next pc=2, one invalid cycle, then instr_pc=2; fetch_count not incremented on bubble.
- Slot instr_pc=32'h0C000005, jump=1, target=26'h0000010 -> pc=32'h0C000010; jr=1 with jr_addr=0x40 asserted simultaneously -> pc=0x40 (jr wins).
- Stall held 3 cycles during RUN -> imem_addr, instr, instr_pc, instr_valid, fetch_count frozen; resumes with next sequential address; stall+branch together -> redirect taken.
- RESET_PC=32'hFFFFFFFF, run 2 cycles -> instr_pc sequence FFFFFFFF, 00000000 (wrap); branch from instr_pc=FFFFFFFF, offset 1 -> target 1.
- Assert rst during a redirect cycle -> pc=RESET_PC, instr_valid=0, fetch_count=0 next edge; branch_taken while instr_valid=0 -> ignored.
